// File: rtl/divider_sequencer.sv
// Sequencing controller for the programmable clock divider path: steps through a
// table of {divide ratio, dwell} entries, producing a tick enable and a divided clock.
module divider_sequencer #(
    parameter int unsigned STEPS = 4,
    parameter int unsigned NW    = 4,
    parameter int unsigned DW    = 4,
    localparam int unsigned SW   = (STEPS > 1) ? $clog2(STEPS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_we,
    input  logic [SW-1:0] cfg_addr,
    input  logic [NW-1:0] cfg_n,
    input  logic [DW-1:0] cfg_dwell,
    input  logic [SW-1:0] last_step,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic [SW-1:0] step,
    output logic          tick,
    output logic          clkout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] step_q, step_d;
    logic [SW-1:0] last_q, last_d;
    logic [NW-1:0] n_act_q, n_act_d;
    logic [DW-1:0] dw_act_q, dw_act_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] tcnt_q, tcnt_d;
    logic          clkout_q, clkout_d;
    logic          done_q, done_d;
    logic          tick_c;

    logic [NW-1:0] n_tbl_q  [STEPS];
    logic [DW-1:0] dw_tbl_q [STEPS];

    // Ratio/dwell table, writable in any state; entries are sampled only at LOAD
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(STEPS); i++) begin
                n_tbl_q[i]  <= '0;
                dw_tbl_q[i] <= '0;
            end
        end else if (cfg_we) begin
            n_tbl_q[cfg_addr]  <= cfg_n;
            dw_tbl_q[cfg_addr] <= cfg_dwell;
        end
    end

    assign tick_c = (state_q == RUN) && (cnt_q == n_act_q);

    // Next-state and datapath update; abort outranks tick, advance and completion
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        last_d   = last_q;
        n_act_d  = n_act_q;
        dw_act_d = dw_act_q;
        cnt_d    = cnt_q;
        tcnt_d   = tcnt_q;
        clkout_d = clkout_q;
        done_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    last_d  = last_step;
                    step_d  = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d  = IDLE;
                    step_d   = '0;
                    clkout_d = 1'b0;
                end else begin
                    n_act_d  = n_tbl_q[step_q];
                    dw_act_d = dw_tbl_q[step_q];
                    cnt_d    = '0;
                    tcnt_d   = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d  = IDLE;
                    step_d   = '0;
                    clkout_d = 1'b0;
                end else if (tick_c) begin
                    cnt_d    = '0;
                    tcnt_d   = tcnt_q + DW'(1);
                    clkout_d = ~clkout_q;
                    if (tcnt_q == dw_act_q) begin
                        if (step_q < last_q) begin
                            step_d  = step_q + SW'(1);
                            state_d = LOAD;
                        end else begin
                            state_d  = IDLE;
                            step_d   = '0;
                            clkout_d = 1'b0;
                            done_d   = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + NW'(1);
                end
            end
            default: begin
                state_d  = IDLE;
                step_d   = '0;
                clkout_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            step_q   <= '0;
            last_q   <= '0;
            n_act_q  <= '0;
            dw_act_q <= '0;
            cnt_q    <= '0;
            tcnt_q   <= '0;
            clkout_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            last_q   <= last_d;
            n_act_q  <= n_act_d;
            dw_act_q <= dw_act_d;
            cnt_q    <= cnt_d;
            tcnt_q   <= tcnt_d;
            clkout_q <= clkout_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign step   = step_q;
    assign tick   = tick_c;
    assign clkout = clkout_q;

endmodule

// File: tb/tb_divider_sequencer.sv
// Bench for divider_sequencer: scripted scenario table, reset check, and random
// sequences against a cycle-list reference model.
module tb_divider_sequencer;

    localparam int unsigned STEPS = 4;
    localparam int unsigned NW    = 4;
    localparam int unsigned DW    = 4;
    localparam int unsigned SW    = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we;
    logic [SW-1:0] cfg_addr;
    logic [NW-1:0] cfg_n;
    logic [DW-1:0] cfg_dwell;
    logic [SW-1:0] last_step;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic [SW-1:0] step;
    logic          tick;
    logic          clkout;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    divider_sequencer #(.STEPS(STEPS), .NW(NW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_n     (cfg_n),
        .cfg_dwell (cfg_dwell),
        .last_step (last_step),
        .start     (start),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .step      (step),
        .tick      (tick),
        .clkout    (clkout)
    );

    typedef struct packed {
        logic          busy;
        logic          done;
        logic [SW-1:0] step;
        logic          tick;
        logic          clkout;
    } obs_t;

    // One scripted scenario; bit k of every mask refers to cycle k of the window
    typedef struct {
        string       name;
        logic [15:0] start_m;
        logic [15:0] abort_m;
        logic [15:0] we_m;
        logic [1:0]  waddr;
        logic [3:0]  wn;
        logic [3:0]  wd;
        logic [15:0] exp_tick;
        logic [15:0] exp_busy;
        logic [15:0] exp_done;
        logic [15:0] exp_clk;
        logic [15:0] exp_step1;
    } scen_t;

    scen_t         scen [7];
    obs_t          q [$];
    logic [NW-1:0] mn [STEPS];
    logic [DW-1:0] md [STEPS];

    task automatic chk(input string name, input int cyc, input logic [3:0] act, input logic [3:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic check_obs(input string tag, input int cyc, input obs_t e);
        chk({tag, ".busy"},   cyc, {3'b0, busy},   {3'b0, e.busy});
        chk({tag, ".done"},   cyc, {3'b0, done},   {3'b0, e.done});
        chk({tag, ".step"},   cyc, {2'b0, step},   {2'b0, e.step});
        chk({tag, ".tick"},   cyc, {3'b0, tick},   {3'b0, e.tick});
        chk({tag, ".clkout"}, cyc, {3'b0, clkout}, {3'b0, e.clkout});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        cfg_we    = 1'b0;
        cfg_addr  = '0;
        cfg_n     = '0;
        cfg_dwell = '0;
        start     = 1'b0;
        abort     = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic wr(input logic [SW-1:0] a, input logic [NW-1:0] n, input logic [DW-1:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_n     = n;
        cfg_dwell = d;
        next_cycle();
        cfg_we    = 1'b0;
    endtask

    task automatic run_scen(input scen_t s);
        obs_t e;
        do_reset();
        wr(2'd0, 4'd1, 4'd1);
        wr(2'd1, 4'd3, 4'd0);
        last_step = 2'd1;
        for (int k = 0; k < 16; k++) begin
            start     = s.start_m[k];
            abort     = s.abort_m[k];
            cfg_we    = s.we_m[k];
            cfg_addr  = s.waddr;
            cfg_n     = s.wn;
            cfg_dwell = s.wd;
            @(negedge clk);
            e = '{busy: s.exp_busy[k], done: s.exp_done[k], step: {1'b0, s.exp_step1[k]},
                  tick: s.exp_tick[k], clkout: s.exp_clk[k]};
            check_obs(s.name, k, e);
            next_cycle();
        end
        clear_inputs();
    endtask

    // Expected per-cycle outputs of a full run, from the start cycle onward
    task automatic build_model(input logic [SW-1:0] lst);
        logic c;
        c = 1'b0;
        q.delete();
        q.push_back(obs_t'(0));
        for (int s = 0; s <= int'(lst); s++) begin
            q.push_back('{1'b1, 1'b0, SW'(s), 1'b0, c});
            for (int dk = 0; dk <= int'(md[s]); dk++) begin
                for (int j = 0; j <= int'(mn[s]); j++) begin
                    q.push_back('{1'b1, 1'b0, SW'(s), (j == int'(mn[s])), c});
                    if (j == int'(mn[s])) c = ~c;
                end
            end
        end
        q.push_back('{1'b0, 1'b1, SW'(0), 1'b0, 1'b0});
        q.push_back(obs_t'(0));
    endtask

    initial begin
        obs_t          e;
        logic [SW-1:0] lst;
        int            ab;

        scen[0] = '{"two_step",   16'h0001, 16'h0000, 16'h0000, 2'd0, 4'd0, 4'd0,
                    16'h0428, 16'h07FE, 16'h0800, 16'h0030, 16'h07C0};
        scen[1] = '{"abort_run",  16'h0041, 16'h0010, 16'h0000, 2'd0, 4'd0, 4'd0,
                    16'h0A08, 16'hFF9E, 16'h0000, 16'h0C10, 16'hF000};
        scen[2] = '{"start_busy", 16'h0009, 16'h0000, 16'h0000, 2'd0, 4'd0, 4'd0,
                    16'h0428, 16'h07FE, 16'h0800, 16'h0030, 16'h07C0};
        scen[3] = '{"live_cfg",   16'h0001, 16'h0000, 16'h0004, 2'd1, 4'd0, 4'd2,
                    16'h03A8, 16'h03FE, 16'h0400, 16'h0130, 16'h03C0};
        scen[4] = '{"back2back",  16'h0801, 16'h0000, 16'h0000, 2'd0, 4'd0, 4'd0,
                    16'h4428, 16'hF7FE, 16'h0800, 16'h8030, 16'h07C0};
        scen[5] = '{"abort_idle", 16'h0001, 16'h0001, 16'h0000, 2'd0, 4'd0, 4'd0,
                    16'h0428, 16'h07FE, 16'h0800, 16'h0030, 16'h07C0};
        scen[6] = '{"abort_load", 16'h0001, 16'h0002, 16'h0000, 2'd0, 4'd0, 4'd0,
                    16'h0000, 16'h0002, 16'h0000, 16'h0000, 16'h0000};

        rst       = 1'b1;
        last_step = '0;
        clear_inputs();
        #1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_obs("reset_state", 0, obs_t'(0));
        next_cycle();

        for (int i = 0; i < 7; i++) run_scen(scen[i]);

        // Mid-run reset must clear outputs and the table (n=0, dwell=0)
        do_reset();
        wr(2'd0, 4'd2, 4'd3);
        last_step = 2'd0;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        repeat (4) next_cycle();
        rst = 1'b1;
        next_cycle();
        @(negedge clk);
        check_obs("rst_hold", 1, obs_t'(0));
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_obs("rst_after", 2, obs_t'(0));
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            e = '{busy: (k <= 2), done: (k == 3), step: '0, tick: (k == 2), clkout: 1'b0};
            check_obs("rst_table", k, e);
            next_cycle();
        end

        // Random tables, optional abort, ignored start pulses and last_step noise mid-run
        for (int r = 0; r < 40; r++) begin
            for (int en = 0; en < int'(STEPS); en++) begin
                mn[en] = NW'($urandom_range(0, 6));
                md[en] = DW'($urandom_range(0, 5));
                wr(SW'(en), mn[en], md[en]);
            end
            lst = SW'($urandom_range(0, 3));
            build_model(lst);
            ab = -1;
            if ($urandom_range(0, 2) == 0) begin
                ab = int'($urandom_range(1, q.size() - 3));
                while (q.size() > ab + 1) void'(q.pop_back());
                q.push_back(obs_t'(0));
                q.push_back(obs_t'(0));
            end
            for (int k = 0; k < q.size(); k++) begin
                start     = (k == 0) || (q[k].busy && ($urandom_range(0, 7) == 0));
                abort     = (k == ab);
                last_step = (k == 0) ? lst : SW'($urandom);
                @(negedge clk);
                check_obs("rand", k, q[k]);
                next_cycle();
            end
            clear_inputs();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
